// File: rtl/core_dg_dec.sv
// ---------------------------------------------------------------------------
// core_dg_dec
//   Two-stage single-error-correcting decoder for the 11-bit parity code that
//   the upstream encoder produces.
//   S1 holds the accepted codeword. S2 holds the decoded byte, the corrected
//   flag and the raw syndrome. A saturating counter tallies the corrected
//   words that leave the block.
//
//   Parity bits are c4, c5 and c7. Data bits are c[3:0], c6, c8, c9 and c10.
//   The syndrome {s2,s1,s0} names the flipped bit as S+3. Bits c[3:0] are not
//   covered by any parity bit, so errors in them cannot be seen.
//
// Ports
//   clk            in   single clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   in_valid       in   codeword present on in_code
//   in_code[10:0]  in   encoded word
//   in_ready       out  block accepts in_code this cycle
//   out_valid      out  decoded result present
//   out_ready      in   downstream accepts the result
//   out_data[7:0]  out  corrected data byte
//   out_corrected  out  a single-bit flip was corrected in this word
//   out_syndrome   out  raw syndrome {s2,s1,s0} before correction
//   cnt_clr        in   synchronous clear of corr_count (wins over increment)
//   corr_count     out  saturating count of corrected words transferred out
// ---------------------------------------------------------------------------
module core_dg_dec #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [10:0]      in_code,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_corrected,
    output logic [2:0]       out_syndrome,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns {corrected, syndrome[2:0], data[7:0]}.
    // Only the four data bits that a parity bit covers can be the target of
    // a correction. For that reason each of those four bits is flipped
    // directly on a match, and a full corrected codeword is never built.
    function automatic logic [11:0] decode(input logic [10:0] c);
        logic [2:0] s;
        logic [7:0] d;
        s[0]   = c[4] ^ c[6] ^ c[8] ^ c[10];
        s[1]   = c[5] ^ c[6] ^ c[9] ^ c[10];
        s[2]   = c[7] ^ c[8] ^ c[9] ^ c[10];
        d[3:0] = c[3:0];
        d[4]   = c[6]  ^ (s == 3'd3);
        d[5]   = c[8]  ^ (s == 3'd5);
        d[6]   = c[9]  ^ (s == 3'd6);
        d[7]   = c[10] ^ (s == 3'd7);
        return {(s != 3'd0), s, d};
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [10:0]      s1_code_q,  s1_code_d;
    logic             s2_valid_q, s2_valid_d;
    logic [7:0]       s2_data_q,  s2_data_d;
    logic             s2_corr_q,  s2_corr_d;
    logic [2:0]       s2_syn_q,   s2_syn_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic             s2_adv;
    logic             in_xfer;
    logic             out_xfer;
    logic [11:0]      dec_s1;

    // S2 frees up when it is empty or its word leaves this cycle. S1 moves
    // into S2 on the same condition, so S1 can also take a new word then.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_valid_q && out_ready;
    assign dec_s1   = decode(s1_code_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_corr_d  = s2_corr_q;
        s2_syn_d   = s2_syn_q;
        cnt_d      = cnt_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_xfer) begin
            s1_code_d = in_code;
        end

        // Data registers load only when a real word moves in. A bubble that
        // moves in leaves the old values on the outputs.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                {s2_corr_d, s2_syn_d, s2_data_d} = dec_s1;
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_xfer && s2_corr_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // ---- S1: accepted codeword ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
    end

    // The codeword is never read while s1_valid_q is low, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_code_q <= s1_code_d;
    end

    // ---- S2: decoded result and correction counter ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= 8'h00;
            s2_corr_q  <= 1'b0;
            s2_syn_q   <= 3'd0;
            cnt_q      <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_corr_q  <= s2_corr_d;
            s2_syn_q   <= s2_syn_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign out_data      = s2_data_q;
    assign out_corrected = s2_corr_q;
    assign out_syndrome  = s2_syn_q;
    assign corr_count    = cnt_q;

endmodule

// File: tb/tb_core_dg_dec.sv
// ---------------------------------------------------------------------------
// tb_core_dg_dec
//   Directed bench for core_dg_dec. The counter width is 2 so that
//   saturation can be reached.
//   Expected values are hand-computed constants. For the streaming sections a
//   small reference decoder builds the expected values instead.
// ---------------------------------------------------------------------------
module tb_core_dg_dec;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [10:0] in_code;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_corrected;
    logic [2:0]  out_syndrome;
    logic        cnt_clr;
    logic [1:0]  corr_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [10:0] w [0:7];

    core_dg_dec #(.CNT_W(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_code       (in_code),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_corrected (out_corrected),
        .out_syndrome  (out_syndrome),
        .cnt_clr       (cnt_clr),
        .corr_count    (corr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decoder: flip codeword bit S+3, then pick out the data bits.
    // Returns {corrected, syndrome, data}.
    function automatic logic [11:0] model(input logic [10:0] cw);
        logic [10:0] fx;
        logic [2:0]  s;
        int          k;
        fx = cw;
        s  = {cw[7] ^ cw[8] ^ cw[9] ^ cw[10],
              cw[5] ^ cw[6] ^ cw[9] ^ cw[10],
              cw[4] ^ cw[6] ^ cw[8] ^ cw[10]};
        if (s != 3'd0) begin
            k = int'(s) + 3;
            fx[k] = ~fx[k];
        end
        return {(s != 3'd0), s, fx[10], fx[9], fx[8], fx[6], fx[3:0]};
    endfunction

    task automatic send_one(input logic [10:0] code, input logic [7:0] e_data,
                            input logic e_corr, input logic [2:0] e_syn,
                            input logic [1:0] e_cnt);
        logic [1:0] c0;
        c0        = corr_count;
        in_valid  = 1'b1;
        in_code   = code;
        out_ready = 1'b1;
        #1;
        chk("one_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        step();
        chk("one_out_valid", out_valid, 1);
        chk("one_data", out_data, e_data);
        chk("one_corrected", out_corrected, e_corr);
        chk("one_syndrome", out_syndrome, e_syn);
        chk("one_cnt_hold", corr_count, c0);
        step();
        chk("one_out_valid_drop", out_valid, 0);
        chk("one_cnt", corr_count, e_cnt);
    endtask

    // Streams n words from w[]. When rnd is 0, out_ready stays low for the
    // first five cycles (three cycles of output stall). When rnd is 1,
    // out_ready is random.
    task automatic run_stream(input int n, input bit rnd);
        int          idx;
        int          oidx;
        logic [11:0] held;
        logic        held_v;
        idx    = 0;
        oidx   = 0;
        held   = '0;
        held_v = 1'b0;
        for (int c = 0; c < 80 && oidx < n; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : (c >= 5);
            in_valid  = (idx < n);
            in_code   = (idx < n) ? w[idx] : 11'h000;
            #1;
            if (held_v) chk("stream_hold", {out_corrected, out_syndrome, out_data}, held);
            if (!rnd && c == 2) begin
                chk("stall_out_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                chk("stream_out", {out_corrected, out_syndrome, out_data}, model(w[oidx]));
                oidx++;
            end
            held_v = out_valid && !out_ready;
            held   = {out_corrected, out_syndrome, out_data};
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 1'b0;
        chk("stream_words_out", oidx, n);
        out_ready = 1'b1;
        step();
        chk("stream_no_extra", out_valid, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_code   = 11'h000;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_corrected", out_corrected, 0);
        chk("rst_syndrome", out_syndrome, 0);
        chk("rst_cnt", corr_count, 0);
        reset_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Single words: clean, parity-covered flips, uncovered flip, saturation
        send_one(11'h525, 8'hA5, 1'b0, 3'd0, 2'd0);
        send_one(11'h425, 8'hA5, 1'b1, 3'd5, 2'd1);
        send_one(11'h527, 8'hA7, 1'b0, 3'd0, 2'd1);
        send_one(11'h125, 8'hA5, 1'b1, 3'd7, 2'd2);
        send_one(11'h535, 8'hA5, 1'b1, 3'd1, 2'd3);
        send_one(11'h565, 8'hA5, 1'b1, 3'd3, 2'd3);
        send_one(11'h725, 8'hA5, 1'b1, 3'd6, 2'd3);
        send_one(11'h7FF, 8'hFF, 1'b0, 3'd0, 2'd3);

        // Four words with a three-cycle output stall
        w[0] = 11'h525; w[1] = 11'h425; w[2] = 11'h7FF; w[3] = 11'h0A3;
        run_stream(4, 1'b0);

        // Eight words under random backpressure
        for (int i = 0; i < 8; i++) w[i] = 11'($urandom);
        run_stream(8, 1'b1);

        // Reset while both stages hold words
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 11'h425;
        step();
        in_code   = 11'h535;
        step();
        in_valid  = 1'b0;
        #1;
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        chk("full_cnt_pre", corr_count, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_cnt", corr_count, 0);
        chk("arst_data", out_data, 8'h00);
        chk("arst_syndrome", out_syndrome, 0);
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("arst_discard", out_valid, 0);
        end

        // Clear wins over a simultaneous corrected transfer
        send_one(11'h425, 8'hA5, 1'b1, 3'd5, 2'd1);
        in_valid = 1'b1;
        in_code  = 11'h125;
        step();
        in_valid = 1'b0;
        step();
        chk("clr_pre_valid", out_valid, 1);
        chk("clr_pre_corr", out_corrected, 1);
        chk("clr_pre_cnt", corr_count, 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_priority", corr_count, 0);
        chk("clr_out_gone", out_valid, 0);
        send_one(11'h565, 8'hA5, 1'b1, 3'd3, 2'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_alone", corr_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/core_dg_dec.md
CORE_DG_DEC -- requirements
Module: core_dg_dec

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the correction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  codeword present on in_code.
REQ-005 SHALL have port in_code  input  11  encoded word from the upstream parity encoder.
REQ-006 SHALL have port in_ready  output  1  block accepts in_code this cycle.
REQ-007 SHALL have port out_valid  output  1  decoded result present.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-009 SHALL have port out_data  output  8  corrected data byte.
REQ-010 SHALL have port out_corrected  output  1  a single-bit flip was corrected in this word.
REQ-011 SHALL have port out_syndrome  output  3  raw syndrome {s2,s1,s0} of this word.
REQ-012 SHALL have port cnt_clr  input  1  synchronous clear of corr_count.
REQ-013 SHALL have port corr_count  output  CNT_W  saturating count of corrected words.

Function
REQ-014 SHALL transfer an input when in_valid && in_ready at a rising edge, and an output when out_valid && out_ready.
REQ-015 SHALL implement two register stages: S1 holds the accepted codeword; S2 holds the decoded result. Latency from input transfer to out_valid is 2 cycles with no backpressure.
REQ-016 SHALL advance S2 when !out_valid || out_ready, and S1 into S2 under the same condition; in_ready = !s1_valid || (S2 advancing). Full throughput is one word per cycle.
REQ-017 SHALL hold out_data, out_corrected and out_syndrome stable while out_valid && !out_ready.
REQ-018 SHALL compute syndrome from S1: s0 = c4^c6^c8^c10; s1 = c5^c6^c9^c10; s2 = c7^c8^c9^c10.
REQ-019 SHALL, for a nonzero syndrome S, invert codeword bit S+3 (S=1 to bit 4, ..., S=7 to bit 10) and set out_corrected=1; for S=0, pass unchanged and set out_corrected=0.
REQ-020 SHALL extract out_data[3:0]=c[3:0], out_data[4]=c6, out_data[5]=c8, out_data[6]=c9, out_data[7]=c10 from the corrected word.
REQ-021 SHALL pass bits c[3:0] uncorrected; errors in those bits are undetectable and produce S=0.
REQ-022 SHALL increment corr_count by 1 on each output transfer with out_corrected=1, saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL give cnt_clr priority over a simultaneous increment; the result is 0.
REQ-024 SHALL never drop or duplicate a word when out_ready toggles arbitrarily.
REQ-025 SHALL compute out_syndrome as the syndrome before correction.

Reset
REQ-026 SHALL, on reset_n low, asynchronously clear S1/S2 valid flags, out_data=0x00, out_corrected=0, out_syndrome=0 and corr_count=0; in_ready=1 during and after reset.
REQ-027 SHALL discard words held in S1/S2 when reset is asserted mid-operation; no output transfer occurs until a new input is accepted after release.

Verification
REQ-028 SHALL pass this check: in_code=0x525, out_ready=1 -> 2 cycles later out_data=0xA5, out_corrected=0, out_syndrome=0, corr_count unchanged.
REQ-029 SHALL pass this check: in_code=0x425 (bit 8 flipped) -> out_data=0xA5, out_corrected=1, out_syndrome=5, corr_count +1.
REQ-030 SHALL pass this check: in_code=0x527 (bit 1 flipped) -> out_data=0xA7, out_corrected=0, out_syndrome=0.
REQ-031 SHALL pass this check: stream 4 words with out_ready low 3 cycles -> in_ready drops after 2 words are held; all 4 words are output in order, unchanged while stalled.
REQ-032 SHALL pass this check: CNT_W=2, 5 corrected words -> corr_count=3; cnt_clr on the same cycle as a corrected transfer -> corr_count=0.
REQ-033 SHALL pass this check: reset_n low with both stages full -> out_valid=0 immediately, corr_count=0, in_ready=1.
